// File: rtl/barrel_pkg.sv
// Shared encodings for the pipelined barrel shifter: operation modes and shift directions.
package barrel_pkg;

  localparam logic [1:0] MODE_ROT  = 2'b00;
  localparam logic [1:0] MODE_LSH  = 2'b01;
  localparam logic [1:0] MODE_ASH  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/barrel_pipe_stage.sv
// One barrel-shifter pipeline stage: conditional shift/rotate by SHIFT bits,
// beat register and valid/ready handshake.
module barrel_pipe_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [$clog2(WIDTH)-1:0]   amt_i,
  input  logic                       dir_i,
  input  logic [1:0]                 mode_i,
  input  logic                       fill_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(WIDTH)-1:0]   amt_o,
  output logic                       dir_o,
  output logic [1:0]                 mode_o,
  output logic                       fill_o,
  output logic                       zero_o
);

  localparam int unsigned AmtW   = $clog2(WIDTH);
  localparam int unsigned AmtBit = $clog2(SHIFT);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AmtW-1:0]  amt_q, amt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] shifted;
  logic             load;

  always_comb begin
    shifted = data_i;
    if (amt_i[AmtBit] && (mode_i != MODE_PASS)) begin
      if (dir_i == DIR_LEFT) begin
        if (mode_i == MODE_ROT) begin
          shifted = {data_i[WIDTH-SHIFT-1:0], data_i[WIDTH-1:WIDTH-SHIFT]};
        end else begin
          shifted = {data_i[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        end
      end else begin
        if (mode_i == MODE_ROT) begin
          shifted = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
        end else begin
          // fill_i is already 0 for logical shifts, the operand MSB for arithmetic
          shifted = {{SHIFT{fill_i}}, data_i[WIDTH-1:SHIFT]};
        end
      end
    end
  end

  assign ready_o = !valid_q || ready_i;
  // Only real beats are captured, so idle X inputs never reach the register
  assign load    = ready_o && valid_i;

  always_comb begin
    valid_d = ready_o ? valid_i : valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    zero_d  = zero_q;
    if (load) begin
      data_d = shifted;
      amt_d  = amt_i;
      dir_d  = dir_i;
      mode_d = mode_i;
      fill_d = fill_i;
      zero_d = (shifted == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      fill_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      zero_q  <= zero_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign dir_o   = dir_q;
  assign mode_o  = mode_q;
  assign fill_o  = fill_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: one registered stage per shift-amount bit,
// rotate / logical / arithmetic / pass modes, valid/ready on both sides.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic entry_fill;

  assign entry_fill = (in_mode == MODE_ASH) && (in_dir == DIR_RIGHT) && in_data[WIDTH-1];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    logic             valid_in, fill_in, dir_in, ready_in;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amt_in;
    logic [1:0]       mode_in;

    logic             valid_w, ready_w, dir_w, fill_w, zero_w;
    logic [WIDTH-1:0] data_w;
    logic [AMT_W-1:0] amt_w;
    logic [1:0]       mode_w;

    if (k == 0) begin : g_head
      assign valid_in = in_valid;
      assign data_in  = in_data;
      assign amt_in   = in_amt;
      assign dir_in   = in_dir;
      assign mode_in  = in_mode;
      assign fill_in  = entry_fill;
    end else begin : g_body
      assign valid_in = g_stage[k-1].valid_w;
      assign data_in  = g_stage[k-1].data_w;
      assign amt_in   = g_stage[k-1].amt_w;
      assign dir_in   = g_stage[k-1].dir_w;
      assign mode_in  = g_stage[k-1].mode_w;
      assign fill_in  = g_stage[k-1].fill_w;
    end

    if (k == AMT_W - 1) begin : g_tail
      logic             unused_tail;
      assign ready_in    = out_ready;
      assign out_valid   = valid_w;
      assign out_data    = data_w;
      assign out_zero    = zero_w;
      assign unused_tail = ^{amt_w, dir_w, mode_w, fill_w};
    end else begin : g_mid
      logic unused_zero;
      assign ready_in    = g_stage[k+1].ready_w;
      assign unused_zero = zero_w;
    end

    barrel_pipe_stage #(
      .WIDTH (WIDTH),
      .SHIFT (2 ** k)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .valid_i (valid_in),
      .ready_o (ready_w),
      .data_i  (data_in),
      .amt_i   (amt_in),
      .dir_i   (dir_in),
      .mode_i  (mode_in),
      .fill_i  (fill_in),
      .valid_o (valid_w),
      .ready_i (ready_in),
      .data_o  (data_w),
      .amt_o   (amt_w),
      .dir_o   (dir_w),
      .mode_o  (mode_w),
      .fill_o  (fill_w),
      .zero_o  (zero_w)
    );
  end

  assign in_ready = g_stage[0].ready_w;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH = 16): directed, back-pressure,
// random streaming and mid-stream reset scenarios.
module tb_pipelined_barrel_shifter;
  import barrel_pkg::*;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_dir, out_valid, out_ready, out_zero;
  logic [W-1:0]  in_data, out_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_mode;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [31:0]  acc;
  } exp_t;

  exp_t        sb[$];
  int          pop_cyc[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pops = 0;
  bit          lat_chk = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          prev_held = 1'b0;
  logic [W-1:0] held_data;
  logic        held_zero;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: whole-word arithmetic on the operand, independent of any stage structure
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input logic dir,
                                         input logic [1:0] mode);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (mode)
      MODE_PASS: return d;
      MODE_ROT: begin
        if (dir == DIR_LEFT) begin
          dd = dd << a;
          return dd[2*W-1:W];
        end
        dd = dd >> a;
        return dd[W-1:0];
      end
      MODE_LSH: return (dir == DIR_LEFT) ? W'(d << a) : W'(d >> a);
      default:  return (dir == DIR_LEFT) ? W'(d << a) : W'($signed(d) >>> a);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_held = 1'b0;
    end else begin
      if (prev_held) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held_data));
        check("stall_zero", 32'(out_zero), 32'(held_zero));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h, required no beat", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_zero", 32'(out_zero), 32'(e.data == '0));
          if (lat_chk) check("latency", cyc - e.acc, 32'd4);
          pops++;
          pop_cyc.push_back(cyc);
        end
      end
      prev_held = out_valid && !out_ready;
      held_data = out_data;
      held_zero = out_zero;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 'x;
    in_amt   = 'x;
    in_dir   = 1'bx;
    in_mode  = 'x;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic dir,
                      input logic [1:0] m, input logic [W-1:0] expv);
    exp_t e;
    bit   ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_mode  = m;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok     = 1'b1;
        e.data = expv;
        e.acc  = cyc;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    check(name, sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]  bd[6];
    logic [AW-1:0] ba[6];
    logic          bdir[6];
    logic [1:0]    bm[6];
    int            idx, p0;
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic          dir;
    logic [1:0]    m;

    reset_n   = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    #22;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed results, out_ready high, latency checked
    lat_chk = 1'b1;
    send(16'hA5C3, 4'd4, DIR_RIGHT, MODE_ROT, 16'h3A5C);
    send(16'h8001, 4'd1, DIR_LEFT, MODE_ROT, 16'h0003);
    send(16'h8000, 4'd15, DIR_RIGHT, MODE_LSH, 16'h0001);
    send(16'h8000, 4'd15, DIR_RIGHT, MODE_ASH, 16'hFFFF);
    send(16'h4000, 4'd14, DIR_RIGHT, MODE_ASH, 16'h0001);
    send(16'h00FF, 4'd8, DIR_LEFT, MODE_ASH, 16'hFF00);
    send(16'h1234, 4'd7, DIR_LEFT, MODE_PASS, 16'h1234);
    send(16'h0001, 4'd1, DIR_RIGHT, MODE_LSH, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      send(16'hBEEF, 4'd0, 1'(i & 1), 2'(i >> 1), 16'hBEEF);
    end
    drain("directed_drain");

    // Back-pressure: six beats offered against a stalled output
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bd[i]   = W'($urandom);
      ba[i]   = AW'($urandom);
      bdir[i] = 1'($urandom);
      bm[i]   = 2'($urandom);
    end
    idx = 0;
    for (int t = 0; t < 10; t++) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        in_data  = bd[idx];
        in_amt   = ba[idx];
        in_dir   = bdir[idx];
        in_mode  = bm[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back('{data: model(bd[idx], int'(ba[idx]), bdir[idx], bm[idx]), acc: cyc});
        idx++;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("bp_accepted", idx, 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 4; i < 6; i++) begin
      send(bd[i], ba[i], bdir[i], bm[i], model(bd[i], int'(ba[i]), bdir[i], bm[i]));
    end
    drain("bp_drain");
    check("bp_pops", pop_cyc.size(), 32'd6);
    if (pop_cyc.size() == 6) check("bp_no_gaps", pop_cyc[5] - pop_cyc[0], 32'd5);

    // Random streaming with random back-pressure
    p0 = pops;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d   = W'($urandom);
      a   = AW'($urandom);
      dir = 1'($urandom);
      m   = 2'($urandom);
      send(d, a, dir, m, model(d, int'(a), dir, m));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("stream_drain");
    check("stream_count", pops - p0, 32'd100);

    // Reset with three beats in flight
    lat_chk = 1'b1;
    send(16'h1111, 4'd3, DIR_LEFT, MODE_ROT, model(16'h1111, 3, DIR_LEFT, MODE_ROT));
    send(16'hF0F0, 4'd5, DIR_RIGHT, MODE_ASH, model(16'hF0F0, 5, DIR_RIGHT, MODE_ASH));
    send(16'h0F0F, 4'd2, DIR_LEFT, MODE_LSH, model(16'h0F0F, 2, DIR_LEFT, MODE_LSH));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    p0 = pops;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_stale", pops - p0, 32'd0);
    send(16'hC001, 4'd9, DIR_RIGHT, MODE_ROT, model(16'hC001, 9, DIR_RIGHT, MODE_ROT));
    drain("midrst_drain");
    check("midrst_after", pops - p0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter that generalises the team's fixed 16-bit left/right rotators.
- Arbitrary power-of-two width.
- Selectable direction and mode: rotate, logical shift or arithmetic shift.
- One register stage per log2 shift stage.
- Valid/ready handshake on both sides, so it drops into streaming datapaths (ALU, display scroller) with back-pressure.

Parameters:
- WIDTH, 16: data width in bits; must be a power of two, >= 4.
- AMT_W, $clog2(WIDTH): localparam; shift-amount width and pipeline depth.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept input beat.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, 0..WIDTH-1.
- in_dir  in  1  0 = right, 1 = left.
- in_mode  in  2  see op encoding.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0; registered alongside out_data.

Behaviour:
- Op encoding (in_mode):
  - 00 rotate.
  - 01 logical shift: zero fill.
  - 10 arithmetic shift: right fills with the operand's original MSB; left is identical to logical.
  - 11 pass-through: data unchanged, amt ignored.
- Pipeline structure:
  - AMT_W stages; stage k (k = 0..AMT_W-1) shifts by 0 or 2^k according to amt bit k of its beat.
  - Each stage registers data, remaining amt, dir, mode, fill bit and valid.
  - Fill bit = in_data[WIDTH-1] when mode = 10 and dir = 0, else 0; captured at stage-0 entry and carried with the beat.
  - Stage k, shifting right, inserts the fill bit into the top 2^k positions for modes 01/10. Shifting left inserts zeros at the bottom. Rotate wraps the bits round.
- Latency: exactly AMT_W cycles from an accepted input (in_valid & in_ready) to out_valid, for every amt including 0, when out_ready stays high.
- Throughput: one beat per cycle with no stalls.
- Per-stage handshake:
  - stage_ready[k] = !valid_q[k] | stage_ready[k+1].
  - stage_ready[AMT_W] = out_ready.
  - in_ready = stage_ready[0].
  - A stage loads only when ready; otherwise it holds all fields.
  - The ready chain is combinational; no bubbles are inserted.
- Capacity: holds AMT_W beats under full back-pressure. in_ready falls in the cycle after the last stage is occupied and the output is stalled. No beat is ever lost or duplicated.
- Output stability: out_data and out_zero stay stable while out_valid & !out_ready.
- Ordering: beats leave in acceptance order; the mix of modes and directions is unrestricted per beat.
- Reset (any time, including mid-stream):
  - All valid_q = 0, data = 0, out_data = 0, out_zero = 0.
  - out_valid = 0, in_ready = 1 once reset_n is high.
  - In-flight beats are discarded.
- Boundary conditions:
  - amt = 0 → data unchanged.
  - amt = WIDTH-1 → maximum shift.
  - in_valid while in_ready = 0 → ignored; the source must hold it.
  - Simultaneous output pop and input push when full → both occur in the same cycle; occupancy unchanged.
- No X on outputs after reset, regardless of input X while in_valid = 0.

Decomposition:
- Package barrel_pkg: mode localparams MODE_ROT = 2'b00, MODE_LSH = 2'b01, MODE_ASH = 2'b10, MODE_PASS = 2'b11; direction constants DIR_RIGHT = 0, DIR_LEFT = 1.
- Sub-module barrel_pipe_stage:
  - Parameters WIDTH, SHIFT (= 2^k).
  - Contains one conditional shift/rotate plus the stage register and ready logic.
  - The top level is a generate loop of AMT_W instances plus the zero-detect on the final stage.

Test Plan (WIDTH = 16):
- Directed results, with out_ready held high: each beat emerges exactly 4 cycles after acceptance.
  - rotate right 0xA5C3 amt 4 → 0x3A5C.
  - rotate left 0x8001 amt 1 → 0x0003.
  - logical right 0x8000 amt 15 → 0x0001.
  - arithmetic right 0x8000 amt 15 → 0xFFFF.
  - arithmetic right 0x4000 amt 14 → 0x0001.
  - arithmetic left 0x00FF amt 8 → 0xFF00.
  - pass 0x1234 amt 7 → 0x1234.
- Zero flag: logical right 0x0001 amt 1 → out_data 0x0000, out_zero = 1. amt 0 on 0xBEEF in any mode → 0xBEEF, still 4-cycle latency.
- Back-pressure: hold out_ready = 0 and offer 6 back-to-back beats.
  - Exactly 4 are accepted, then in_ready = 0.
  - Release out_ready; all 6 results appear in order with correct values and no gaps once streaming.
- Full-rate streaming: 100 random beats (random mode/dir/amt) with random out_ready. A scoreboard against a reference model reports zero mismatches and zero losses.
- Reset mid-stream: assert reset_n low with 3 beats in flight.
  - out_valid = 0 and out_data = 0 immediately (asynchronous).
  - After release, no stale beat emerges; the next beat completes with normal latency.
